sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock FIFO with register-array storage and pointer/flag control.
- Parametrised in data width, depth (power of two) and read mode: standard registered read, or first-word-fall-through (FWFT).
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses.
- Sits between producer and consumer blocks in the same clock domain. Reused as the base for later CDC variants.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W (16).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT: pop/acknowledge of the head word).
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds a freshly read word (standard) / head word valid (FWFT).
- full  out  1  no free entries.
- empty  out  1  no stored entries.
- almost_full  out  1  count >= af_thr.
- almost_empty  out  1  count <= ae_thr.
- af_thr  in  ADDR_W+1  almost-full threshold; quasi-static.
- ae_thr  in  ADDR_W+1  almost-empty threshold; quasi-static.
- count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Pointers
  - wptr and rptr are ADDR_W+1 bits. The low ADDR_W bits address storage; the MSB is the wrap bit.
  - Pointers increment by 1 and roll from 2**(ADDR_W+1)-1 to 0.
- Flags and count
  - empty = (wptr == rptr).
  - full = (low ADDR_W bits equal) and (MSBs differ).
  - count = (wptr - rptr) modulo 2**(ADDR_W+1).
  - empty, full, count, almost_full and almost_empty are combinational from the registered pointers and thresholds. They update in the cycle after the accepting edge, with no extra latency.
- Accept rules
  - wr_acc = wr_en & !full. On wr_acc, mem[wptr low] <= din and wptr++.
  - rd_acc = rd_en & !empty. On rd_acc, rptr++.
  - When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
  - Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
- Errors
  - overflow is registered: it is high for exactly one cycle, in the cycle after wr_en & full.
  - underflow is registered the same way, for rd_en & empty.
  - Rejected requests do not change pointers, storage or dout.
- Standard mode (FWFT=0)
  - On rd_acc, dout <= mem[rptr low] at the same edge. Read latency is 1 cycle.
  - dout_valid is high for one cycle after each rd_acc.
  - dout holds its last value otherwise.
- FWFT mode (FWFT=1)
  - dout = mem[rptr low], combinational.
  - dout_valid = !empty.
  - A write into an empty FIFO is visible on dout in the next cycle.
  - rd_acc advances to the next word, which is visible on dout in the following cycle.
- Reset (asynchronous assert, synchronous release)
  - wptr = rptr = 0; empty = 1, full = 0, count = 0.
  - dout = 0 (standard mode); dout_valid = 0; overflow = underflow = 0.
  - almost_empty = 1 (count 0 <= any ae_thr). almost_full = 1 only if af_thr = 0.
  - Storage is not reset.
  - Reset mid-operation discards all contents. The first word after release is the first word written after release.
- Threshold corner values
  - af_thr > 2**ADDR_W: almost_full is never asserted.
  - ae_thr >= 2**ADDR_W: almost_empty is always asserted.

Decomposition:
- Package fifo_pkg holds:
  - mode constants FIFO_STD = 0 and FIFO_FWFT = 1;
  - a pointer-width constant function, ptr_w(addr_w) = addr_w + 1.
- One sub-module, fifo_ptr_cmp (parameter ADDR_W):
  - inputs: wptr, rptr, af_thr, ae_thr;
  - outputs: empty, full, count, almost_full, almost_empty;
  - purely combinational.
- sync_fifo instantiates fifo_ptr_cmp and owns the pointers, storage, read register and error pulses.

Test Plan:
1. Fill/empty (FWFT=0, ADDR_W=4): write 0x00..0x0F, then read 16 words -> full = 1 after the 16th write, count = 16; data returns 0x00..0x0F, each one cycle after rd_en; empty = 1 after the last read.
2. Wrap-around: run 40 write/read pairs with 3 words resident -> pointers wrap past 31, data order is preserved, count stays 3, full is never set.
3. Boundaries: write while full -> overflow pulses 1 cycle and count stays 16. Read while empty -> underflow pulses 1 cycle and dout is unchanged. Simultaneous wr_en & rd_en when full -> read accepted, write rejected, count = 15.
4. FWFT=1: write 0xA5 to an empty FIFO -> next cycle dout = 0xA5 and dout_valid = 1 with no rd_en. Pulse rd_en once -> empty = 1 the next cycle.
5. Thresholds: af_thr = 12, ae_thr = 3, write 12 words -> almost_empty drops after the 4th write and almost_full rises after the 12th. Set af_thr = 17 -> almost_full stays 0 even at count = 16.
6. Reset mid-operation: with 9 words stored, pull rst_n low asynchronously between edges -> immediately empty = 1, count = 0, dout_valid = 0. After release, write 0x3C -> it is the first word read.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO family: read-mode selectors and pointer width helper.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // One extra MSB on each pointer distinguishes full from empty.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_cmp.sv
// Combinational FIFO status from wrap-bit pointers: empty/full, occupancy and threshold flags.
module fifo_ptr_cmp
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic [ptr_w(ADDR_W)-1:0] wptr_i,
  input  logic [ptr_w(ADDR_W)-1:0] rptr_i,
  input  logic [ptr_w(ADDR_W)-1:0] af_thr_i,
  input  logic [ptr_w(ADDR_W)-1:0] ae_thr_i,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [ptr_w(ADDR_W)-1:0] count_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o
);

  always_comb begin
    count_o        = wptr_i - rptr_i;
    empty_o        = (wptr_i == rptr_i);
    full_o         = (wptr_i[ADDR_W-1:0] == rptr_i[ADDR_W-1:0]) &&
                     (wptr_i[ADDR_W] != rptr_i[ADDR_W]);
    // Thresholds above depth never trip almost_full; ae_thr >= depth pins almost_empty.
    almost_full_o  = (count_o >= af_thr_i);
    almost_empty_o = (count_o <= ae_thr_i);
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock register-array FIFO, standard (1-cycle registered read) or first-word-fall-through.
// Writes are refused when full and reads when empty; each refusal raises a one-cycle error pulse.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FWFT   = FIFO_STD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  input  logic [ptr_w(ADDR_W)-1:0] af_thr,
  input  logic [ptr_w(ADDR_W)-1:0] ae_thr,
  output logic [ptr_w(ADDR_W)-1:0] count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW    = ptr_w(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic              wr_acc, rd_acc;
  logic              overflow_q, underflow_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] waddr, raddr;

  fifo_ptr_cmp #(.ADDR_W(ADDR_W)) u_ptr_cmp (
    .wptr_i        (wptr_q),
    .rptr_i        (rptr_q),
    .af_thr_i      (af_thr),
    .ae_thr_i      (ae_thr),
    .empty_o       (empty),
    .full_o        (full),
    .count_o       (count),
    .almost_full_o (almost_full),
    .almost_empty_o(almost_empty)
  );

  // A read never frees room for a same-cycle write, nor a write feed a same-cycle read.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign waddr  = wptr_q[ADDR_W-1:0];
  assign raddr  = rptr_q[ADDR_W-1:0];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= din;
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout       = mem_q[raddr];
    assign dout_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem_q[raddr];
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT-mode FIFO driven by the same stimulus.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] din;
  logic [AW:0]   af_thr, ae_thr;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_dout_valid, f_dout_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(FIFO_STD)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dout_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .af_thr(af_thr), .ae_thr(ae_thr),
    .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .af_thr(af_thr), .ae_thr(ae_thr),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1; din = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    af_thr = 5'd16; ae_thr = 5'd2;
    #12;
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_count", s_count, 0);
    chk("rst_dout", s_dout, 0);
    chk("rst_dvld", s_dout_valid, 0);
    chk("rst_fdvld", f_dout_valid, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Fill and empty.
    for (int i = 0; i < 16; i++) begin
      push(DW'(i));
      chk("fill_count", s_count, 32'(i + 1));
      chk("fill_full", s_full, (i == 15) ? 1 : 0);
    end
    chk("fill_fwft_full", f_full, 1);
    for (int i = 0; i < 16; i++) begin
      chk("fwft_head", f_dout, 32'(i));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("drain_dout", s_dout, 32'(i));
      chk("drain_dvld", s_dout_valid, 1);
    end
    chk("drain_empty", s_empty, 1);
    chk("drain_count", s_count, 0);
    tick();
    chk("idle_dvld", s_dout_valid, 0);
    chk("idle_dout_hold", s_dout, 32'h0F);

    // Read while empty.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_pulse", s_udf, 1);
    chk("udf_dout", s_dout, 32'h0F);
    chk("udf_dvld", s_dout_valid, 0);
    tick();
    chk("udf_clear", s_udf, 0);

    // Write while full, then simultaneous read/write while full.
    for (int i = 0; i < 16; i++) push(DW'(8'h20 + i));
    push(8'hEE);
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_count", s_count, 16);
    tick();
    chk("ovf_clear", s_ovf, 0);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_full_count", s_count, 15);
    chk("rw_full_dout", s_dout, 32'h20);
    chk("rw_full_ovf", s_ovf, 1);
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("rw_drain", s_dout, 32'(8'h20 + i));
    end
    chk("rw_drain_empty", s_empty, 1);

    // Wrap-around with three words resident.
    for (int i = 0; i < 3; i++) push(DW'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = DW'(8'h43 + i);
      tick();
      chk("wrap_dout", s_dout, 32'(8'h40 + i));
      chk("wrap_count", s_count, 3);
      chk("wrap_full", s_full, 0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrap_tail", s_dout, 32'(8'h68 + i));
    end
    rd_en = 1'b0;
    chk("wrap_empty", s_empty, 1);

    // Thresholds.
    af_thr = 5'd12; ae_thr = 5'd3;
    #1;
    chk("thr_ae0", s_ae, 1);
    chk("thr_af0", s_af, 0);
    for (int i = 1; i <= 12; i++) begin
      push(DW'(8'h80 + i));
      chk("thr_ae", s_ae, (i <= 3) ? 1 : 0);
      chk("thr_af", s_af, (i >= 12) ? 1 : 0);
    end
    for (int i = 13; i <= 16; i++) push(DW'(8'h80 + i));
    af_thr = 5'd17; ae_thr = 5'd16;
    #1;
    chk("thr_af17", s_af, 0);
    chk("thr_ae16", s_ae, 1);
    chk("thr_cnt16", s_count, 16);
    af_thr = 5'd16;
    #1;
    chk("thr_af16", s_af, 1);

    // Reset mid-operation with 9 words stored.
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("mid_count9", s_count, 9);
    chk("mid_dvld_pre", s_dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_empty", s_empty, 1);
    chk("mid_count", s_count, 0);
    chk("mid_dvld", s_dout_valid, 0);
    chk("mid_fdvld", f_dout_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    push(8'h3C);
    push(8'h3D);
    chk("post_fhead", f_dout, 32'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_first", s_dout, 32'h3C);
    chk("post_fnext", f_dout, 32'h3D);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_empty", f_empty, 1);

    // FWFT fall-through.
    push(8'hA5);
    chk("fwft_dout", f_dout, 32'hA5);
    chk("fwft_dvld", f_dout_valid, 1);
    chk("fwft_std_dvld", s_dout_valid, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_pop_empty", f_empty, 1);
    chk("fwft_pop_dvld", f_dout_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
